// File: rtl/instr_fetch.sv
// Instruction fetch stage: keeps the fetch PC, issues word requests to
// instruction memory, buffers returned words with their PCs in a small FIFO
// for decode, and discards stale responses after a branch/jump redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_pc  [DEPTH];
  logic [31:0]   fifo_ins [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [CW:0]   inflight;
  logic          credit_ok;
  logic          hs;
  logic          pop;
  logic          rsp_take;
  logic          push;
  logic [31:0]   push_pc;
  logic [CW-1:0] remaining;

  // Credits cover both buffered words and words still in flight, so an
  // accepted request always has a FIFO slot waiting for its response.
  assign inflight  = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok = inflight < DEPTH_W;

  assign imem_req_valid = (state == RUN) && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc;

  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? fifo_ins[head] : NOP;
  assign pc_out      = instr_valid ? fifo_pc[head]  : 32'h0;

  assign hs       = imem_req_valid && imem_req_ready;
  assign pop      = instr_valid && !stall;
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  assign push     = (state == RUN) && rsp_take && !redirect_valid;

  // Requests since the last redirect are consecutive words, so the oldest
  // unanswered one sits outstanding words behind fetch_pc.
  assign push_pc   = fetch_pc - {{(30-CW){1'b0}}, outstanding, 2'b00};
  assign remaining = outstanding - CW'(rsp_take);

  // Buffer storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail]  <= push_pc;
      fifo_ins[tail] <= imem_rsp_data;
    end
  end

  // Fetch FSM, PC, occupancy and in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
        end
        default: begin
          if (redirect_valid) begin
            fetch_pc    <= redirect_pc & ~32'h3;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= remaining;
            drop_cnt    <= remaining;
            state       <= (remaining == '0) ? RUN : DRAIN;
          end else if (state == RUN) begin
            if (hs) begin
              fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(hs) - CW'(push);
            count       <= count + CW'(push) - CW'(pop);
            if (push) begin
              tail <= tail + 1'b1;
            end
            if (pop) begin
              head <= head + 1'b1;
            end
          end else begin
            // DRAIN: every response belongs to a request issued before the
            // redirect and is thrown away.
            if (rsp_take) begin
              drop_cnt    <= drop_cnt - 1'b1;
              outstanding <= outstanding - 1'b1;
              if (drop_cnt == CW'(1)) begin
                state <= RUN;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with configurable latency,
// reference PC model and a scoreboard of expected {pc, word} pairs.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .instr_valid(instr_valid),
    .instruction(instruction), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    int lat; int rdy; int stl; int pre;
    logic [31:0] rpc; int post; logic [31:0] exp_first;
  } vec_t;

  ent_t  sb[$];
  mreq_t memq[$];
  vec_t  vecs[5];

  int n_vec = 0, n_bad = 0;
  int cyc = 0, n_pop = 0, n_hs = 0;
  int first_hs = -1, first_iv = -1;
  int cfg_lat = 1, cfg_rdy = 100, cfg_stl = 0;
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] first_pc = 32'hDEAD_DEAD;
  logic [31:0] last_hs_addr = 32'h0;
  bit want_first = 1'b1, saw_wrap = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    chk_eq({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    chk_eq({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    chk_eq({tag, "_instruction"}, instruction, NOP);
    chk_eq({tag, "_pc_out"}, pc_out, 32'h0);
  endtask

  // One clock cycle: drive inputs, sample and score at the falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input int exp_rv);
    bit hs, pop;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = ($urandom_range(99) < cfg_rdy);
    stall          = ($urandom_range(99) < cfg_stl);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    if (exp_rv >= 0) chk_eq("req_valid_expected", {31'b0, imem_req_valid}, exp_rv);
    if (redir) chk_eq("req_gated_by_redirect", {31'b0, imem_req_valid}, 32'd0);
    if (imem_req_valid) chk_eq("req_addr", imem_req_addr, exp_addr);
    if (instr_valid) begin
      if (sb.size() == 0) chk_eq("head_without_request", pc_out, 32'hFFFF_FFFF);
      else begin
        chk_eq("head_pc", pc_out, sb[0].pc);
        chk_eq("head_instruction", instruction, sb[0].ins);
      end
      if (first_iv < 0) first_iv = cyc;
    end else begin
      chk_eq("empty_instruction", instruction, NOP);
      chk_eq("empty_pc", pc_out, 32'h0);
    end
    hs  = imem_req_valid && imem_req_ready;
    pop = instr_valid && !stall;
    if (redir) begin
      sb.delete();
      exp_addr   = rpc & ~32'h3;
      want_first = 1'b1;
      first_pc   = 32'hDEAD_DEAD;
    end else begin
      if (pop && sb.size() > 0) begin
        if (want_first) begin
          first_pc   = sb[0].pc;
          want_first = 1'b0;
        end
        void'(sb.pop_front());
        n_pop++;
      end
      if (hs) begin
        sb.push_back({exp_addr, mem_word(exp_addr)});
        memq.push_back('{imem_req_addr, cyc + cfg_lat});
        if (imem_req_addr == 32'h0 && last_hs_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
        last_hs_addr = imem_req_addr;
        exp_addr = exp_addr + 32'd4;
        n_hs++;
        if (first_hs < 0) first_hs = cyc;
        chk_eq("credit_within_depth", {31'b0, sb.size() <= DEPTH}, 32'd1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    cfg_rdy = 0;
    cfg_stl = 0;
    while ((sb.size() > 0 || memq.size() > 0) && n < 300) begin
      step(1'b0, 32'h0, -1);
      n++;
    end
    chk_eq("drain_done", sb.size() + memq.size(), 32'd0);
  endtask

  // Two requests in flight at latency 3, redirect to 0x2002 at step rstep.
  task automatic seq_redirect(input int rstep);
    drain();
    cfg_lat = 3; cfg_stl = 0; cfg_rdy = 100;
    step(1'b0, 32'h0, 1);
    step(1'b0, 32'h0, 1);
    cfg_rdy = 0;
    if (rstep == 3) step(1'b0, 32'h0, 1);
    cfg_rdy = 100;
    step(1'b1, 32'h0000_2002, 0);
    chk_eq("redir_flush_iv", {31'b0, instr_valid}, 32'd0);
    if (rstep == 2) step(1'b0, 32'h0, 0);
    step(1'b0, 32'h0, 0);
    step(1'b0, 32'h0, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, -1);
    drain();
    chk_eq("redir_first_pc", first_pc, 32'h0000_2000);
  endtask

  initial begin
    int p0, h0;
    logic [31:0] hold_pc;

    vecs[0] = '{3, 100,  0,  6, 32'h0000_2002, 20, 32'h0000_2000};
    vecs[1] = '{1, 100,  0,  5, 32'h0000_3000, 20, 32'h0000_3000};
    vecs[2] = '{2,  50, 30, 10, 32'h0000_4001, 40, 32'h0000_4000};
    vecs[3] = '{1, 100,  0,  3, 32'hFFFF_FFF4, 12, 32'hFFFF_FFF4};
    vecs[4] = '{4,  60, 50, 15, 32'h0000_5003, 60, 32'h0000_5000};

    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // Startup: IDLE for one cycle, then streaming at one word per cycle.
    rst_n = 1'b1;
    cfg_lat = 1; cfg_rdy = 100; cfg_stl = 0;
    step(1'b0, 32'h0, 0);
    step(1'b0, 32'h0, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, -1);
    p0 = n_pop;
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, -1);
    chk_eq("first_valid_latency", first_iv - first_hs, 32'd2);
    chk_eq("throughput_16", n_pop - p0, 32'd16);

    // Stall: bounded fetch, head held, then in-order drain.
    cfg_stl = 100;
    h0 = n_hs;
    hold_pc = sb[0].pc;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, -1);
    chk_eq("stall_accept_bound", {31'b0, (n_hs - h0) <= DEPTH}, 32'd1);
    chk_eq("stall_head_hold", pc_out, hold_pc);
    cfg_stl = 0;
    p0 = n_pop;
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, -1);
    chk_eq("stall_release_pops", n_pop - p0, DEPTH);

    // Redirect with nothing outstanding: request at the new PC next cycle.
    cfg_stl = 100;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, -1);
    step(1'b1, 32'h0000_7000, -1);
    chk_eq("idle_redir_flush_iv", {31'b0, instr_valid}, 32'd0);
    step(1'b0, 32'h0, 1);
    drain();
    chk_eq("idle_redir_first_pc", first_pc, 32'h0000_7000);

    seq_redirect(2);
    seq_redirect(3);

    for (int v = 0; v < 5; v++) begin
      cfg_lat = vecs[v].lat; cfg_rdy = vecs[v].rdy; cfg_stl = vecs[v].stl;
      for (int i = 0; i < vecs[v].pre; i++) step(1'b0, 32'h0, -1);
      step(1'b1, vecs[v].rpc, -1);
      chk_eq("vec_flush_iv", {31'b0, instr_valid}, 32'd0);
      cfg_lat = vecs[v].lat; cfg_rdy = vecs[v].rdy; cfg_stl = vecs[v].stl;
      for (int i = 0; i < vecs[v].post; i++) step(1'b0, 32'h0, -1);
      drain();
      chk_eq("vec_first_pc", first_pc, vecs[v].exp_first);
    end
    chk_eq("pc_wrap_seen", {31'b0, saw_wrap}, 32'd1);

    // Reset in the middle of fetching clears outputs at once.
    cfg_lat = 1; cfg_rdy = 100; cfg_stl = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, -1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb.delete(); memq.delete();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    exp_addr = RESET_PC; want_first = 1'b1; first_pc = 32'hDEAD_DEAD;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 32'h0, 0);
    step(1'b0, 32'h0, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, -1);
    drain();
    chk_eq("midreset_first_pc", first_pc, RESET_PC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the rv32 core, directly upstream of instruction decode. Keeps the fetch PC, issues word requests to instruction memory over a valid/ready request channel with in-order responses, and buffers returned words with their PCs in a small FIFO. The head entry drives the 32-bit `instruction` word that decode consumes. Branch/jump redirects flush the buffer and discard in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, 4: FIFO entries; power of two, at least 2; also bounds outstanding requests.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response word valid; in request order, at least 1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  branch/jump taken; restart fetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored, treated as 00.
- `stall`  in  1  decode cannot accept this cycle.
- `instr_valid`  out  1  head entry valid.
- `instruction`  out  32  head instruction word; 32'h0000_0013 (NOP) when empty.
- `pc_out`  out  32  PC of head entry; 0 when empty.

## Operation
- State: `fetch_pc`, FIFO (DEPTH × {pc, instr}), `count` (FIFO occupancy), `outstanding` (accepted, unanswered requests), `drop_cnt`, FSM state. Counters are clog2(DEPTH)+1 bits wide.
- FSM states:
  - IDLE: entered on reset. No requests. Moves to RUN on the first clock edge after `rst_n` deasserts.
  - RUN: normal fetching.
  - DRAIN: discarding stale responses after a redirect.
- Request issue, RUN only: `imem_req_valid` = (`outstanding` + `count` < DEPTH) && !`redirect_valid`. `imem_req_addr` = `fetch_pc`.
- Handshake (valid && ready): `outstanding`++, `fetch_pc` += 4. Overflow wraps modulo 2^32.
- While valid && !ready, addr holds stable. The only exception is a redirect, which may drop `imem_req_valid` without a handshake.
- Response in RUN with `outstanding` > 0: push {pc, `imem_rsp_data`} into the FIFO and decrement `outstanding`. The pushed pc is the address of the matching request, kept as a per-request PC queue or computed as `fetch_pc` − 4·`outstanding`.
- A response arriving with `outstanding` == 0 is ignored.
- Dequeue: `instr_valid` && !`stall` pops the head. Push and pop in the same cycle keep `count` unchanged.
- Redirect (any non-IDLE state, priority over everything else):
  - flush the FIFO (`count` = 0);
  - `fetch_pc` = {`redirect_pc`[31:2], 2'b00};
  - a response arriving in the same cycle is dropped;
  - `drop_cnt` = `outstanding` − (`imem_rsp_valid` ? 1 : 0) and `outstanding` is set to the same value;
  - if the result is 0, stay in (or return to) RUN; otherwise go to DRAIN.
- DRAIN:
  - no requests issued;
  - each response decrements `drop_cnt` and `outstanding` and is discarded;
  - on the response that brings `drop_cnt` to 0, go to RUN;
  - a redirect in DRAIN updates `fetch_pc`, decrements `drop_cnt` if a response arrives that cycle, and stays in DRAIN.
- `stall` does not block issue or response capture; the credit check alone prevents overflow.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `instr_valid`=0, `instruction`=32'h0000_0013, `pc_out`=0, `count`=`outstanding`=`drop_cnt`=0, state IDLE.
- Reset asserted mid-operation clears all state immediately. The memory side is reset alongside, so no stale responses follow.
- Earliest first request: the cycle after `rst_n` rises.
- Latency: request accepted in cycle t, response in t+1, `instr_valid` high in t+2 (FIFO head output is registered state; outputs are combinational from the head).
- Throughput: one instruction per cycle with DEPTH ≥ 3 and 1-cycle memory.
- `redirect_valid` cycle r: `instr_valid`=0 from r+1. With nothing outstanding, the first request at `redirect_pc` is issued in r+1.
- Outputs depend combinationally only on registered state. `imem_req_valid` is additionally gated by `redirect_valid`.

## Test plan
- Reset with RESET_PC=0x100, memory always ready, 1-cycle latency, no stall -> addresses 0x100, 0x104, 0x108…; `instr_valid` rises 2 cycles after the first accept; `pc_out` increments by 4 every cycle.
- Hold `stall`=1 for 10 cycles -> at most DEPTH requests accepted; `instruction`/`pc_out` stable; on release, DEPTH entries drain in order with no loss or duplication.
- Memory latency 3, two requests outstanding, `redirect_valid` with `redirect_pc`=0x2002 -> FIFO empties; both stale responses discarded in DRAIN; next request addr 0x2000; first valid `pc_out`=0x2000.
- Redirect in the same cycle as a response and a pending request -> response dropped, no handshake that cycle, `drop_cnt` = `outstanding`−1.
- `imem_req_ready` toggled randomly against a reference PC model -> addr held stable while valid && !ready; instruction/PC pairs match expected memory contents.
- `fetch_pc`=0xFFFF_FFFC -> next request addr 0x0000_0000; assert `rst_n` low mid-fetch -> all outputs return to reset values the same cycle.
